// File: rtl/md_pkg.sv
// md_pkg: shared encodings for the RV32M multiply/divide unit
package md_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} md_state_e;
  localparam logic [6:0] FUNCT7_M = 7'b0000001;
endpackage

// File: rtl/alu_md_unit.sv
// alu_md_unit: iterative radix-2 multiply / restoring divide for RV32M
module alu_md_unit
  import md_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            ready_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN) + 1;
  md_state_e         state_q, state_d;
  md_op_e            op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;
  md_op_e            op_in;
  logic              accept, div_in, s1, s2, dz_in, ovf_in, special;
  logic [XLEN-1:0]   abs1, abs2, fast_res;
  logic [XLEN:0]     mul_sum, rem_sh;
  logic [XLEN-1:0]   diff, quot, rem;
  logic              ge;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  logic [XLEN-1:0]   fix_res;
  assign ready_o  = (state_q == IDLE) || (state_q == DONE);
  assign done_o   = state_q == DONE;
  assign result_o = result_q;
  // operand decode: signedness, magnitudes and the architecturally fixed divide cases
  always_comb begin
    op_in    = md_op_e'(funct3_i);
    accept   = start_i && ready_o && !kill_i;
    div_in   = funct3_i[2];
    s1       = rs1_i[XLEN-1] && (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    s2       = rs2_i[XLEN-1] && (op_in inside {OP_MULH, OP_DIV, OP_REM});
    abs1     = s1 ? -rs1_i : rs1_i;
    abs2     = s2 ? -rs2_i : rs2_i;
    dz_in    = rs2_i == '0;
    ovf_in   = (op_in inside {OP_DIV, OP_REM}) && rs1_i == {1'b1, {(XLEN-1){1'b0}}} && rs2_i == '1;
    special  = FAST_SPECIAL && div_in && (dz_in || ovf_in);
    fast_res = dz_in ? (funct3_i[1] ? rs1_i : '1) : (funct3_i[1] ? '0 : rs1_i);
  end
  // one iteration of shift-add and of restoring divide, plus the final sign fix-up
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    ge       = rem_sh >= {1'b0, opnd_q};
    diff     = rem_sh[XLEN-1:0] - opnd_q;
    div_next = {ge ? diff : rem_sh[XLEN-1:0], acc_q[XLEN-2:0], ge};
    prod     = negq_q ? -acc_q : acc_q;
    quot     = dz_q ? '1 : (negq_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
    rem      = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fix_res  = op_q[2] ? (op_q[1] ? rem : quot)
                       : (op_q == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  // next-state: kill beats start; accept loads operands; CALC iterates until the counter hits zero
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    dz_d     = dz_q;
    result_d = result_q;
    if (kill_i) begin
      state_d = IDLE;
    end else if (accept) begin
      op_d    = op_in;
      negq_d  = s1 ^ s2;
      negr_d  = s1;
      dz_d    = dz_in;
      cnt_d   = CW'(XLEN - 1);
      opnd_d  = div_in ? abs2 : abs1;
      acc_d   = {{XLEN{1'b0}}, div_in ? abs1 : abs2};
      state_d = special ? DONE : CALC;
      if (special) result_d = fast_res;
    end else begin
      case (state_q)
        CALC: begin
          acc_d   = op_q[2] ? div_next : mul_next;
          state_d = cnt_q == '0 ? FIX : CALC;
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        end
        FIX: begin
          result_d = fix_res;
          state_d  = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end
  // state and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      dz_q     <= dz_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_alu_md_unit.sv
// tb_alu_md_unit: scoreboard bench for alu_md_unit (fast and looped special cases)
module tb_alu_md_unit;
  import md_pkg::*;
  logic clk = 0, rst_n = 0, kill = 0, start1 = 0, start0 = 0;
  logic [2:0] f3 = 0;
  logic [31:0] rs1 = 0, rs2 = 0;
  logic ready1, done1, ready0, done0;
  logic [31:0] res1, res0;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {logic [31:0] res; int lat; int t;} exp_t;
  exp_t q1[$], q0[$];
  alu_md_unit #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .kill_i(kill), .funct3_i(f3),
    .rs1_i(rs1), .rs2_i(rs2), .ready_o(ready1), .done_o(done1), .result_o(res1));
  alu_md_unit #(.XLEN(32), .FAST_SPECIAL(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .kill_i(kill), .funct3_i(f3),
    .rs1_i(rs1), .rs2_i(rs2), .ready_o(ready0), .done_o(done0), .result_o(res0));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic mon(input bit s, input logic [31:0] act);
    exp_t e;
    if (s ? q0.size() == 0 : q1.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done dut%0d: got result %h expected no done", s, act);
      return;
    end
    if (s) e = q0.pop_front(); else e = q1.pop_front();
    chk($sformatf("result_dut%0d", s), act, e.res);
    chk($sformatf("latency_dut%0d", s), cyc - e.t, e.lat);
  endtask
  always @(negedge clk) begin
    if (done1) mon(1'b0, res1);
    if (done0) mon(1'b1, res0);
  end
  task automatic go(input bit s, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] r, input int lat, input bit push);
    exp_t e;
    f3 = f; rs1 = a; rs2 = b;
    e.res = r; e.lat = lat; e.t = cyc;
    if (push && s) q0.push_back(e);
    if (push && !s) q1.push_back(e);
    if (s) start0 = 1; else start1 = 1;
    @(negedge clk);
    start0 = 0; start1 = 0;
  endtask
  task automatic wait_ready(input bit s);
    int n = 0;
    while (!(s ? ready0 : ready1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout dut%0d: got ready=0 expected ready=1", s);
    end
  endtask
  initial begin
    int n;
    #1;
    chk("reset_ready", ready1, 1);
    chk("reset_done", done1, 0);
    chk("reset_result", res1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    go(0, OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1);
    repeat (5) @(negedge clk);
    chk("mul_busy_ready", ready1, 0);
    wait_ready(0);
    go(0, OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1); wait_ready(0);
    go(0, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1); wait_ready(0);
    go(0, OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 1); wait_ready(0);
    go(0, OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, 1); wait_ready(0);
    go(0, OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, 1); wait_ready(0);
    go(0, OP_DIVU, 32'd7, 32'd2, 32'd3, 34, 1); wait_ready(0);
    go(0, OP_REMU, 32'd7, 32'd2, 32'd1, 34, 1); wait_ready(0);
    @(negedge clk);
    go(0, OP_DIV, 32'd100, 32'd7, 32'd0, 0, 0);
    repeat (8) @(negedge clk);
    kill = 1;
    @(negedge clk);
    kill = 0;
    chk("kill_ready", ready1, 1);
    chk("kill_result", res1, 32'd1);
    repeat (40) @(negedge clk);
    chk("kill_result_late", res1, 32'd1);
    kill = 1;
    go(0, OP_MUL, 32'd3, 32'd3, 32'd0, 0, 0);
    kill = 0;
    chk("kill_start_ready", ready1, 1);
    repeat (40) @(negedge clk);
    chk("kill_start_result", res1, 32'd1);
    go(0, OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1); wait_ready(0);
    go(0, OP_REM, 32'd5, 32'd0, 32'd5, 1, 1); wait_ready(0);
    go(0, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1); wait_ready(0);
    go(0, OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1); wait_ready(0);
    go(1, OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 34, 1); wait_ready(1);
    go(1, OP_REM, 32'd5, 32'd0, 32'd5, 34, 1); wait_ready(1);
    go(1, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, 1); wait_ready(1);
    go(1, OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 34, 1); wait_ready(1);
    @(negedge clk);
    go(0, OP_MULHU, 32'h12345678, 32'h9ABCDEF0, 32'd0, 0, 0);
    repeat (5) @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_mid_ready", ready1, 1);
    chk("rst_mid_done", done1, 0);
    chk("rst_mid_result", res1, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    go(0, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1);
    repeat (3) @(negedge clk);
    go(0, OP_MUL, 32'd2, 32'd3, 32'd6, 0, 0);
    wait_ready(0);
    n = 0;
    while ((q1.size() != 0 || q0.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q1.size() + q0.size());
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_md_unit.md
# alu_md_unit

Parametrised iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the execute stage. It sits beside the single-cycle ALU. The decoder steers an M-extension instruction (funct7 = 0000001) here with a one-cycle start pulse. The core stalls on ready_o and writes result_o back when done_o pulses. It decodes funct3 for operation and signedness, runs a radix-2 shift-add / restoring-divide loop, and short-circuits the divide-by-zero and signed-overflow corner cases.

## Interface
- XLEN, 32, operand and result width; must be ≥ 4 and a power of two.
- FAST_SPECIAL, 1, when 1, divide-by-zero and overflow complete in one cycle; when 0, they run the full loop and are corrected in FIX.
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- start_i  input  1  request; accepted only on a rising edge where ready_o = 1.
- kill_i  input  1  flush; aborts any operation in flight.
- funct3_i  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_i  input  XLEN  multiplicand or dividend.
- rs2_i  input  XLEN  multiplier or divisor.
- ready_o  output  1  unit can accept start_i.
- done_o  output  1  one-cycle pulse; result_o is valid.
- result_o  output  XLEN  result, held from done_o until the next done_o.

## Operation
- States:
  - IDLE: ready_o = 1.
  - CALC: XLEN iterations.
  - FIX: sign correction and result select.
  - DONE: done_o = 1 and ready_o = 1.
- Reset values:
  - state = IDLE, ready_o = 1, done_o = 0, result_o = 0.
  - Internal accumulator, operand and counter registers are 0.
- Start handling:
  - On accept, latch funct3_i, |rs1|, |rs2| and the sign flags.
  - Signed operands: rs1 for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM. All others are unsigned.
  - MUL is treated as unsigned; its low XLEN bits are identical to the signed product.
- Multiply:
  - 2·XLEN accumulator, shift-add one bit per CALC cycle.
  - In FIX, negate the product if exactly one operand is signed-negative.
  - MUL selects bits [XLEN-1:0]; MULH* select bits [2·XLEN-1:XLEN].
- Divide:
  - Restoring division, one quotient bit per CALC cycle.
  - In FIX, negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
- Divide special cases (RISC-V mandated):
  - Divisor = 0: quotient = all ones, remainder = rs1.
  - Signed rs1 = 100…0 with rs2 = all ones: quotient = rs1, remainder = 0.
  - FAST_SPECIAL = 1: IDLE → DONE directly.
- Transitions:
  - IDLE → CALC on accepted start_i.
  - CALC → FIX when the counter reaches 0.
  - FIX → DONE.
  - DONE → CALC on a new accepted start_i, otherwise → IDLE.
- kill_i: any state → IDLE at the next edge.
  - kill_i has priority over start_i in the same cycle.
  - No done_o is produced; result_o keeps its previous value.
  - kill_i in IDLE has no effect.
- start_i while ready_o = 0 is ignored and never queued.
- Reset asserted mid-operation returns all registers to their reset values immediately, without a clock.

## Timing
- Start sampled at edge E0.
- ready_o = 0 from E0 until the DONE state.
- CALC occupies edges E1..E(XLEN); FIX is entered at E(XLEN).
- done_o is high for exactly one cycle, starting after edge E(XLEN+1). Normal latency is XLEN+2 cycles (34 at XLEN = 32).
- Special cases with FAST_SPECIAL = 1: done_o is high in the cycle after E0 (latency 1).
- Back-to-back: start_i in the DONE cycle is accepted. This gives a throughput of one op per XLEN+2 cycles.
- Counter width is $clog2(XLEN)+1 and counts down from XLEN-1. There is no wrap: the counter is reloaded only on accept.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package md_pkg holds:
  - the md_op_e enum (funct3 encodings above);
  - the md_state_e enum (IDLE, CALC, FIX, DONE);
  - the M-extension funct7 constant 7'b0000001.
- No sub-module is needed. The datapath (abs, shift-add or subtract, negate) stays in one module, alu_md_unit.

## Test plan
- XLEN = 32, MUL with rs1 = 7, rs2 = 0xFFFFFFFD → result_o = 0xFFFFFFEB; done_o exactly 34 cycles after the start edge; ready_o low throughout.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. DIVU 7 / 2 → 3. REMU 7 / 2 → 1. Issue back-to-back, with each start_i in the previous DONE cycle.
- DIV 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, each with done_o one cycle after start. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0. Repeat with FAST_SPECIAL = 0: same values, 34-cycle latency.
- kill_i at cycle 10 of a DIV → ready_o = 1 next cycle, no done_o, result_o unchanged. kill_i and start_i together in IDLE → start ignored.
- rst_ni low mid-CALC → outputs at reset values immediately. start_i while busy → ignored; the original result is delivered unchanged.
